// File: rtl/bat_regfile.sv
// bat_regfile: bank of WIDTH-bit registers with load/inc/dec, a priority bus read mux,
// ALU/output taps, sticky bus-conflict detection and a halt-mode debug port.
module bat_regfile #(
    parameter int WIDTH     = 16,
    parameter int REG_COUNT = 8,
    parameter int TAP_A     = 0,
    parameter int TAP_B     = 1,
    parameter int OUT_IDX   = REG_COUNT - 1,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     BUS_IN,
    output logic [WIDTH-1:0]     BUS_OUT,
    output logic                 BUS_DRIVE,
    input  logic [REG_COUNT-1:0] REGS_EN,
    input  logic [REG_COUNT-1:0] REGS_RW,
    input  logic [REG_COUNT-1:0] REGS_INC,
    input  logic [REG_COUNT-1:0] REGS_DEC,
    input  logic                 HALT,
    input  logic [AW-1:0]        DBG_ADDR,
    input  logic                 DBG_WE,
    input  logic                 DBG_RE,
    input  logic [WIDTH-1:0]     DBG_WDATA,
    output logic [WIDTH-1:0]     DBG_RDATA,
    output logic                 DBG_RVALID,
    output logic                 DBG_ERR,
    output logic [WIDTH-1:0]     ALU_IN1,
    output logic [WIDTH-1:0]     ALU_IN2,
    output logic [WIDTH-1:0]     OUT,
    output logic                 BUS_CONFLICT
);

    localparam logic [REG_COUNT-1:0] LSB_ONE = {{(REG_COUNT-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     regs [REG_COUNT];
    logic [REG_COUNT-1:0] rd_sel;
    logic [REG_COUNT-1:0] ld_sel;
    logic [REG_COUNT-1:0] dbg_hit;
    logic [WIDTH-1:0]     bus_mux;
    logic [WIDTH-1:0]     dbg_rd_val;
    logic                 multi_rd;
    logic                 dbg_in_range;
    logic [WIDTH-1:0]     dbg_rdata_p1;
    logic                 vld_p1;
    logic                 dbg_err_q;
    logic                 conflict_q;

    function automatic logic [WIDTH-1:0] step_wrap(input logic [WIDTH-1:0] v, input logic up);
        logic [WIDTH-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return up ? v + one : v - one;
    endfunction

    // Halt masks every CPU-side request for the cycle it is high.
    assign rd_sel   = HALT ? '0 : (REGS_EN & ~REGS_RW);
    assign ld_sel   = HALT ? '0 : (REGS_EN & REGS_RW);
    assign multi_rd = (rd_sel & (rd_sel - LSB_ONE)) != '0;

    always_comb begin
        bus_mux = '0;
        for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (rd_sel[i]) bus_mux = regs[i];
        end
    end

    assign BUS_OUT   = bus_mux;
    assign BUS_DRIVE = |rd_sel;

    // Addresses past REG_COUNT hit nothing, so they read back as zero.
    always_comb begin
        dbg_hit    = '0;
        dbg_rd_val = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (DBG_ADDR == AW'(i)) begin
                dbg_hit[i] = 1'b1;
                dbg_rd_val = regs[i];
            end
        end
    end

    assign dbg_in_range = |dbg_hit;

    always_ff @(posedge CLK) begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (RST) begin
                regs[i] <= '0;
            end else if (HALT) begin
                if (DBG_WE && dbg_hit[i]) regs[i] <= DBG_WDATA;
            end else if (ld_sel[i]) begin
                regs[i] <= BUS_IN;
            end else if (REGS_INC[i] != REGS_DEC[i]) begin
                regs[i] <= step_wrap(regs[i], REGS_INC[i]);
            end
        end
    end

    // Stage p1: registered debug read data and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1       <= 1'b0;
            dbg_rdata_p1 <= '0;
            dbg_err_q    <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            vld_p1 <= HALT && DBG_RE;
            if (HALT && DBG_RE) dbg_rdata_p1 <= dbg_rd_val;
            if (HALT && (DBG_WE || DBG_RE) && !dbg_in_range) dbg_err_q <= 1'b1;
            if (multi_rd) conflict_q <= 1'b1;
        end
    end

    assign DBG_RDATA    = dbg_rdata_p1;
    assign DBG_RVALID   = vld_p1;
    assign DBG_ERR      = dbg_err_q;
    assign BUS_CONFLICT = conflict_q;

    assign ALU_IN1 = regs[TAP_A];
    assign ALU_IN2 = regs[TAP_B];
    assign OUT     = regs[OUT_IDX];

endmodule

// File: tb/tb_bat_regfile.sv
// Testbench for bat_regfile: directed vector table, out-of-range and narrow-width
// sequences, then randomized traffic against a behavioural model.
module tb_bat_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance: WIDTH=16, REG_COUNT=8
    logic        rst0, halt0, we0, re0, drv0, rv0, err0, cf0;
    logic [15:0] bin0, wd0, bout0, rd0, a10, a20, o0;
    logic [7:0]  en0, rw0, inc0, dec0;
    logic [2:0]  ad0;

    bat_regfile u0 (
        .CLK(clk), .RST(rst0), .BUS_IN(bin0), .BUS_OUT(bout0), .BUS_DRIVE(drv0),
        .REGS_EN(en0), .REGS_RW(rw0), .REGS_INC(inc0), .REGS_DEC(dec0), .HALT(halt0),
        .DBG_ADDR(ad0), .DBG_WE(we0), .DBG_RE(re0), .DBG_WDATA(wd0), .DBG_RDATA(rd0),
        .DBG_RVALID(rv0), .DBG_ERR(err0), .ALU_IN1(a10), .ALU_IN2(a20), .OUT(o0),
        .BUS_CONFLICT(cf0)
    );

    // Non-power-of-two bank: REG_COUNT=6
    logic        rst1, halt1, we1, re1, drv1, rv1, err1, cf1;
    logic [15:0] bin1, wd1, bout1, rd1, a11, a21, o1;
    logic [5:0]  en1, rw1, inc1, dec1;
    logic [2:0]  ad1;

    bat_regfile #(.REG_COUNT(6)) u1 (
        .CLK(clk), .RST(rst1), .BUS_IN(bin1), .BUS_OUT(bout1), .BUS_DRIVE(drv1),
        .REGS_EN(en1), .REGS_RW(rw1), .REGS_INC(inc1), .REGS_DEC(dec1), .HALT(halt1),
        .DBG_ADDR(ad1), .DBG_WE(we1), .DBG_RE(re1), .DBG_WDATA(wd1), .DBG_RDATA(rd1),
        .DBG_RVALID(rv1), .DBG_ERR(err1), .ALU_IN1(a11), .ALU_IN2(a21), .OUT(o1),
        .BUS_CONFLICT(cf1)
    );

    // Narrow bank: WIDTH=8, REG_COUNT=4, TAP_A=2, OUT_IDX=0
    logic       rst2, halt2, we2, re2, drv2, rv2, err2, cf2;
    logic [7:0] bin2, wd2, bout2, rd2, a12, a22, o2;
    logic [3:0] en2, rw2, inc2, dec2;
    logic [1:0] ad2;

    bat_regfile #(.WIDTH(8), .REG_COUNT(4), .TAP_A(2), .OUT_IDX(0)) u2 (
        .CLK(clk), .RST(rst2), .BUS_IN(bin2), .BUS_OUT(bout2), .BUS_DRIVE(drv2),
        .REGS_EN(en2), .REGS_RW(rw2), .REGS_INC(inc2), .REGS_DEC(dec2), .HALT(halt2),
        .DBG_ADDR(ad2), .DBG_WE(we2), .DBG_RE(re2), .DBG_WDATA(wd2), .DBG_RDATA(rd2),
        .DBG_RVALID(rv2), .DBG_ERR(err2), .ALU_IN1(a12), .ALU_IN2(a22), .OUT(o2),
        .BUS_CONFLICT(cf2)
    );

    typedef struct {
        logic        rst, halt;
        logic [7:0]  en, rw, inc, dec;
        logic [15:0] bin;
        logic [2:0]  addr;
        logic        we, re;
        logic [15:0] wd;
        logic [15:0] e_bus;
        logic        e_drv;
        logic [15:0] e_a1, e_a2, e_out, e_rd;
        logic        e_rv, e_err, e_cf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic halt, input logic [7:0] en, input logic [7:0] rw,
                       input logic [7:0] inc, input logic [7:0] dec, input logic [15:0] bin,
                       input logic [2:0] addr, input logic we, input logic re, input logic [15:0] wd,
                       input logic [15:0] e_bus, input logic e_drv, input logic [15:0] e_a1,
                       input logic [15:0] e_a2, input logic [15:0] e_out, input logic [15:0] e_rd,
                       input logic e_rv, input logic e_err, input logic e_cf);
        vec_t v;
        v.rst = rst; v.halt = halt; v.en = en; v.rw = rw; v.inc = inc; v.dec = dec;
        v.bin = bin; v.addr = addr; v.we = we; v.re = re; v.wd = wd;
        v.e_bus = e_bus; v.e_drv = e_drv; v.e_a1 = e_a1; v.e_a2 = e_a2; v.e_out = e_out;
        v.e_rd = e_rd; v.e_rv = e_rv; v.e_err = e_err; v.e_cf = e_cf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          m [8];
    logic [15:0] m_rd;
    logic        m_rv, m_err, m_cf;

    initial begin
        rst0 = 1; halt0 = 0; we0 = 0; re0 = 0; bin0 = 0; wd0 = 0; en0 = 0; rw0 = 0; inc0 = 0; dec0 = 0; ad0 = 0;
        rst1 = 1; halt1 = 0; we1 = 0; re1 = 0; bin1 = 0; wd1 = 0; en1 = 0; rw1 = 0; inc1 = 0; dec1 = 0; ad1 = 0;
        rst2 = 1; halt2 = 0; we2 = 0; re2 = 0; bin2 = 0; wd2 = 0; en2 = 0; rw2 = 0; inc2 = 0; dec2 = 0; ad2 = 0;
        tick();
        rst0 = 0; rst1 = 0; rst2 = 0;

        // Expected outputs are as seen mid-cycle, before that row's own edge.
        //  rst halt en     rw     inc    dec    bin       ad we re wd         bus      drv a1        a2        out       rdata     rv er cf
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h04, 8'h04, 8'h00, 8'h00, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h04, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h1234, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h01, 8'h01, 8'h00, 8'h00, 16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 8'h01, 8'h01, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h02, 8'h02, 8'h02, 8'h00, 16'h0005, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h08, 8'h08, 8'h00, 8'h00, 16'h0033, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h20, 8'h20, 8'h00, 8'h00, 16'h0055, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h28, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0033, 1, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 0, 8'h20, 8'h00, 8'h20, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0055, 1, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 0, 8'h20, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0056, 1, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 1, 8'h20, 8'h00, 8'h80, 8'h00, 16'h0000, 7, 1, 0, 16'hBEEF, 16'h0000, 0, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 1, 8'h00, 8'h00, 8'h80, 8'h00, 16'h0000, 7, 0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0005, 16'hBEEF, 16'h0000, 0, 0, 1);
        add(0, 1, 8'h00, 8'h00, 8'h80, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0005, 16'hBEEF, 16'hBEEF, 1, 0, 1);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 1, 1, 16'h1111, 16'h0000, 0, 16'hFFFF, 16'h0005, 16'hBEEF, 16'hBEEF, 0, 0, 1);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h1111, 16'hBEEF, 16'h0005, 1, 0, 1);
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 1, 1, 16'hAAAA, 16'h0000, 0, 16'hFFFF, 16'h1111, 16'hBEEF, 16'h1111, 1, 0, 1);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 7, 0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h1111, 16'hBEEF, 16'h1111, 0, 0, 1);
        add(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 7, 0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h1111, 16'hBEEF, 16'hBEEF, 1, 0, 1);
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            rst0 = tbl[k].rst; halt0 = tbl[k].halt; en0 = tbl[k].en; rw0 = tbl[k].rw;
            inc0 = tbl[k].inc; dec0 = tbl[k].dec; bin0 = tbl[k].bin; ad0 = tbl[k].addr;
            we0 = tbl[k].we; re0 = tbl[k].re; wd0 = tbl[k].wd;
            @(negedge clk);
            chk($sformatf("v%0d_bus_out", k), 32'(bout0), 32'(tbl[k].e_bus));
            chk($sformatf("v%0d_bus_drive", k), 32'(drv0), 32'(tbl[k].e_drv));
            chk($sformatf("v%0d_alu_in1", k), 32'(a10), 32'(tbl[k].e_a1));
            chk($sformatf("v%0d_alu_in2", k), 32'(a20), 32'(tbl[k].e_a2));
            chk($sformatf("v%0d_out", k), 32'(o0), 32'(tbl[k].e_out));
            chk($sformatf("v%0d_dbg_rdata", k), 32'(rd0), 32'(tbl[k].e_rd));
            chk($sformatf("v%0d_dbg_rvalid", k), 32'(rv0), 32'(tbl[k].e_rv));
            chk($sformatf("v%0d_dbg_err", k), 32'(err0), 32'(tbl[k].e_err));
            chk($sformatf("v%0d_bus_conflict", k), 32'(cf0), 32'(tbl[k].e_cf));
            tick();
        end

        // Out-of-range debug accesses on the 6-register bank
        ad1 = 3'd7; re1 = 1; we1 = 1; wd1 = 16'h9999;
        tick();
        chk("u1_nohalt_err", 32'(err1), 0);
        chk("u1_nohalt_rvalid", 32'(rv1), 0);
        halt1 = 1; ad1 = 3'd2; we1 = 1; re1 = 0; wd1 = 16'h7777;
        tick();
        we1 = 0; re1 = 1;
        tick();
        chk("u1_rd2_rdata", 32'(rd1), 32'h7777);
        chk("u1_rd2_rvalid", 32'(rv1), 1);
        chk("u1_rd2_err", 32'(err1), 0);
        ad1 = 3'd7;
        tick();
        chk("u1_oor_rdata", 32'(rd1), 0);
        chk("u1_oor_rvalid", 32'(rv1), 1);
        chk("u1_oor_err", 32'(err1), 1);
        re1 = 0; we1 = 1; ad1 = 3'd6; wd1 = 16'hFFFF;
        tick();
        we1 = 0;
        chk("u1_oor_wr_rvalid", 32'(rv1), 0);
        chk("u1_err_sticky", 32'(err1), 1);
        chk("u1_out_untouched", 32'(o1), 0);
        for (int i = 0; i < 6; i++) begin
            ad1 = 3'(i); re1 = 1;
            tick();
            chk($sformatf("u1_scan_r%0d", i), 32'(rd1), (i == 2) ? 32'h7777 : 32'h0);
        end
        re1 = 0; halt1 = 0; rst1 = 1;
        tick();
        rst1 = 0;
        chk("u1_err_cleared", 32'(err1), 0);

        // Narrow-width bank with relocated taps
        chk("u2_reset_alu1", 32'(a12), 0);
        en2 = 4'b0100; rw2 = 4'b0100; bin2 = 8'hFF;
        tick();
        en2 = 0; rw2 = 0;
        chk("u2_load_alu1", 32'(a12), 32'hFF);
        inc2 = 4'b0100;
        tick();
        inc2 = 0;
        chk("u2_wrap_inc", 32'(a12), 32'h00);
        dec2 = 4'b0100;
        tick();
        dec2 = 0;
        chk("u2_wrap_dec", 32'(a12), 32'hFF);
        en2 = 4'b0001; rw2 = 4'b0001; bin2 = 8'h3C;
        tick();
        en2 = 4'b0101; rw2 = 0;
        #1;
        chk("u2_out_tap", 32'(o2), 32'h3C);
        chk("u2_bus_lowest", 32'(bout2), 32'h3C);
        chk("u2_bus_drive", 32'(drv2), 1);
        tick();
        en2 = 0;
        chk("u2_conflict", 32'(cf2), 1);
        halt2 = 1; we2 = 1; ad2 = 2'd1; wd2 = 8'hA5;
        tick();
        we2 = 0;
        chk("u2_dbg_wr_alu2", 32'(a22), 32'hA5);
        re2 = 1; ad2 = 2'd2;
        tick();
        re2 = 0;
        chk("u2_dbg_rdata", 32'(rd2), 32'hFF);
        chk("u2_dbg_rvalid", 32'(rv2), 1);
        tick();
        chk("u2_dbg_rvalid_pulse", 32'(rv2), 0);
        halt2 = 0;

        // Randomized traffic on the default bank against the behavioural model
        rst0 = 1;
        tick();
        rst0 = 0;
        for (int i = 0; i < 8; i++) m[i] = 0;
        m_rd = 0; m_rv = 0; m_err = 0; m_cf = 0;
        for (int n = 0; n < 600; n++) begin
            int          readers;
            logic [15:0] e_bus;
            rst0  = ($urandom_range(0, 49) == 0);
            halt0 = ($urandom_range(0, 3) == 0);
            en0   = 8'($urandom) & 8'($urandom);
            rw0   = 8'($urandom);
            inc0  = 8'($urandom);
            dec0  = 8'($urandom);
            bin0  = 16'($urandom);
            ad0   = 3'($urandom);
            we0   = 1'($urandom);
            re0   = 1'($urandom);
            wd0   = 16'($urandom);
            readers = 0;
            e_bus   = 0;
            if (!halt0) begin
                for (int i = 7; i >= 0; i--) begin
                    if (en0[i] && !rw0[i]) begin
                        e_bus = 16'(m[i]);
                        readers++;
                    end
                end
            end
            @(negedge clk);
            chk("rnd_bus_out", 32'(bout0), 32'(e_bus));
            chk("rnd_bus_drive", 32'(drv0), (readers > 0) ? 32'd1 : 32'd0);
            chk("rnd_alu_in1", 32'(a10), 32'(m[0]));
            chk("rnd_alu_in2", 32'(a20), 32'(m[1]));
            chk("rnd_out", 32'(o0), 32'(m[7]));
            chk("rnd_dbg_rdata", 32'(rd0), 32'(m_rd));
            chk("rnd_dbg_rvalid", 32'(rv0), 32'(m_rv));
            chk("rnd_dbg_err", 32'(err0), 32'(m_err));
            chk("rnd_bus_conflict", 32'(cf0), 32'(m_cf));
            if (rst0) begin
                for (int i = 0; i < 8; i++) m[i] = 0;
                m_rd = 0; m_rv = 0; m_err = 0; m_cf = 0;
            end else if (halt0) begin
                m_rv = re0;
                if (re0) m_rd = 16'(m[ad0]);
                if (we0) m[ad0] = int'(wd0);
            end else begin
                m_rv = 0;
                if (readers >= 2) m_cf = 1;
                for (int i = 0; i < 8; i++) begin
                    if (en0[i] && rw0[i]) m[i] = int'(bin0);
                    else if (inc0[i] && !dec0[i]) m[i] = (m[i] + 1) % 65536;
                    else if (dec0[i] && !inc0[i]) m[i] = (m[i] + 65535) % 65536;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
